// File: rtl/ge_pkg.sv
// Shared types, constants and helpers for the game round driver.
// Fields are laid out LSB-first in the order the LFSR window maps them.
package ge_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRIVE,
        S_SAMPLE,
        S_FIN
    } state_t;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam logic [6:0]  FOLD_THRESH  = 7'd100;
    localparam logic [6:0]  FOLD_OFFSET  = 7'd64;

    typedef struct packed {
        logic [2:0] luck3;
        logic [2:0] timing;
        logic [2:0] slide;
        logic       weather;
        logic [1:0] luck;
        logic [1:0] movement;
        logic [1:0] breakfast;
        logic [6:0] hard;
        logic [6:0] work;
        logic [6:0] random1;
        logic [6:0] speed;
    } fields_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
    endfunction

    function automatic logic [6:0] fold(input logic [6:0] v);
        return (v > FOLD_THRESH) ? v - FOLD_OFFSET : v;
    endfunction

    function automatic fields_t map_fields(input logic [43:0] w);
        fields_t f;
        f         = fields_t'(w);
        f.speed   = fold(f.speed);
        f.work    = fold(f.work);
        f.hard    = fold(f.hard);
        return f;
    endfunction

endpackage

// File: rtl/ge_lfsr16.sv
// 16-bit Galois LFSR; a zero seed is swapped for the default so the
// register can never lock up at zero.
module ge_lfsr16
    import ge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= DEFAULT_SEED;
        end else if (load) begin
            q <= (seed == 16'h0000) ? DEFAULT_SEED : seed;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/ge_round_driver.sv
// Batch driver: builds a 44-bit stimulus word from three LFSR steps per
// round, drives it to the game evaluator and tallies pass/fail statistics.
module ge_round_driver
    import ge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  num_rounds,
    input  logic [15:0] seed,
    output logic [6:0]  speed,
    output logic [6:0]  random1,
    output logic [6:0]  work,
    output logic [6:0]  hard,
    output logic [1:0]  breakfast,
    output logic [1:0]  movement,
    output logic [1:0]  luck,
    output logic        weather,
    output logic [2:0]  slide,
    output logic [2:0]  timing,
    output logic [2:0]  luck3,
    input  logic        pass3,
    output logic        busy,
    output logic        done,
    output logic [7:0]  pass_cnt,
    output logic [7:0]  fail_cnt,
    output logic [7:0]  streak_max
);

    state_t      state;
    state_t      state_nxt;
    logic        lfsr_load;
    logic        lfsr_step;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_nxt;
    logic [1:0]  ld_cnt;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [7:0]  rounds_left;
    logic [7:0]  cur_streak;
    logic [7:0]  streak_inc;
    fields_t     fld;

    ge_lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .seed (seed),
        .step (lfsr_step),
        .q    (lfsr_q)
    );

    // third LOAD step is consumed combinationally as w2
    assign lfsr_nxt   = lfsr_next(lfsr_q);
    assign streak_inc = cur_streak + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    lfsr_load = 1'b1;
                    state_nxt = (num_rounds == 8'd0) ? S_FIN : S_LOAD;
                end
            end
            S_LOAD: begin
                lfsr_step = 1'b1;
                if (ld_cnt == 2'd2) begin
                    state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                state_nxt = (rounds_left > 8'd1) ? S_LOAD : S_FIN;
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_cnt      <= 2'd0;
            w0          <= 16'h0000;
            w1          <= 16'h0000;
            rounds_left <= 8'd0;
            cur_streak  <= 8'd0;
            pass_cnt    <= 8'd0;
            fail_cnt    <= 8'd0;
            streak_max  <= 8'd0;
            fld         <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                rounds_left <= num_rounds;
                ld_cnt      <= 2'd0;
                cur_streak  <= 8'd0;
                pass_cnt    <= 8'd0;
                fail_cnt    <= 8'd0;
                streak_max  <= 8'd0;
            end
            if (state == S_LOAD) begin
                ld_cnt <= ld_cnt + 2'd1;
                if (ld_cnt == 2'd0) begin
                    w0 <= lfsr_nxt;
                end
                if (ld_cnt == 2'd1) begin
                    w1 <= lfsr_nxt;
                end
                if (ld_cnt == 2'd2) begin
                    ld_cnt <= 2'd0;
                    fld    <= map_fields({lfsr_nxt[11:0], w1, w0});
                end
            end
            if (state == S_SAMPLE) begin
                rounds_left <= rounds_left - 8'd1;
                if (pass3) begin
                    pass_cnt   <= pass_cnt + 8'd1;
                    cur_streak <= streak_inc;
                    if (streak_inc > streak_max) begin
                        streak_max <= streak_inc;
                    end
                end else begin
                    fail_cnt   <= fail_cnt + 8'd1;
                    cur_streak <= 8'd0;
                end
            end
        end
    end

    assign speed     = fld.speed;
    assign random1   = fld.random1;
    assign work      = fld.work;
    assign hard      = fld.hard;
    assign breakfast = fld.breakfast;
    assign movement  = fld.movement;
    assign luck      = fld.luck;
    assign weather   = fld.weather;
    assign slide     = fld.slide;
    assign timing    = fld.timing;
    assign luck3     = fld.luck3;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_FIN);

endmodule

// File: tb/tb_ge_round_driver.sv
// Self-checking bench for ge_round_driver with a cycle-level timing model
// and a behavioural LFSR/field reference.
module tb_ge_round_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  num_rounds;
    logic [15:0] seed;
    logic [6:0]  speed, random1, work, hard;
    logic [1:0]  breakfast, movement, luck;
    logic        weather;
    logic [2:0]  slide, timing, luck3;
    logic        pass3;
    logic        busy, done;
    logic [7:0]  pass_cnt, fail_cnt, streak_max;

    int vecs = 0;
    int errs = 0;
    logic [43:0] obs [256];
    logic [43:0] keep [256];

    ge_round_driver dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_rounds (num_rounds),
        .seed       (seed),
        .speed      (speed),
        .random1    (random1),
        .work       (work),
        .hard       (hard),
        .breakfast  (breakfast),
        .movement   (movement),
        .luck       (luck),
        .weather    (weather),
        .slide      (slide),
        .timing     (timing),
        .luck3      (luck3),
        .pass3      (pass3),
        .busy       (busy),
        .done       (done),
        .pass_cnt   (pass_cnt),
        .fail_cnt   (fail_cnt),
        .streak_max (streak_max)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_step(input logic [15:0] x);
        logic [15:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 16'hB400;
        return y;
    endfunction

    function automatic logic [6:0] ref_fold(input logic [6:0] v);
        if (v > 7'd100) return v - 7'd64;
        return v;
    endfunction

    function automatic logic [43:0] packed_out();
        return {luck3, timing, slide, weather, luck, movement,
                breakfast, hard, work, random1, speed};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_batch(input int n, input logic [15:0] sd,
                             input logic [255:0] pat, input bit poke);
        logic [15:0] l;
        logic [47:0] w;
        logic [43:0] e;
        logic [43:0] got;
        int pc, fc, st, sm;
        l  = (sd == 16'h0000) ? 16'hACE1 : sd;
        pc = 0; fc = 0; st = 0; sm = 0;
        start = 1'b1;
        num_rounds = n[7:0];
        seed = sd;
        tick();
        start = 1'b0;
        num_rounds = 8'($urandom);
        seed = 16'($urandom);
        vecs++;
        if (busy !== 1'b1 || done !== (n == 0)) begin
            errs++;
            $display("FAIL start_accept busy=%b done=%b n=%0d", busy, done, n);
        end
        for (int r = 0; r < n; r++) begin
            for (int j = 0; j < 3; j++) begin
                l = ref_step(l);
                w[16*j +: 16] = l;
            end
            e = w[43:0];
            e[6:0]   = ref_fold(w[6:0]);
            e[20:14] = ref_fold(w[20:14]);
            e[27:21] = ref_fold(w[27:21]);
            tick();
            tick();
            tick();
            got = packed_out();
            obs[r] = got;
            vecs++;
            if (got !== e || done !== 1'b0) begin
                errs++;
                $display("FAIL drive_fields r=%0d got=%h exp=%h done=%b",
                         r, got, e, done);
            end
            vecs++;
            if (speed > 7'd100 || work > 7'd100 || hard > 7'd100) begin
                errs++;
                $display("FAIL fold_range r=%0d sp=%0d wk=%0d hd=%0d",
                         r, speed, work, hard);
            end
            pass3 = pat[r];
            if (poke && r == 0) begin
                start = 1'b1;
                num_rounds = 8'd3;
            end
            tick();
            start = 1'b0;
            vecs++;
            if (packed_out() !== e || done !== 1'b0 || busy !== 1'b1) begin
                errs++;
                $display("FAIL sample_hold r=%0d got=%h exp=%h done=%b",
                         r, packed_out(), e, done);
            end
            if (pat[r]) begin
                pc++;
                st++;
                if (st > sm) sm = st;
            end else begin
                fc++;
                st = 0;
            end
            tick();
        end
        vecs++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errs++;
            $display("FAIL done_timing done=%b busy=%b n=%0d", done, busy, n);
        end
        vecs++;
        if (pass_cnt !== pc[7:0] || fail_cnt !== fc[7:0] ||
            streak_max !== sm[7:0]) begin
            errs++;
            $display("FAIL batch_stats got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                     pass_cnt, fail_cnt, streak_max, pc, fc, sm);
        end
        if (poke) begin
            start = 1'b1;
            num_rounds = 8'd5;
        end
        tick();
        start = 1'b0;
        vecs++;
        if (done !== 1'b0 || busy !== 1'b0 || pass_cnt !== pc[7:0] ||
            fail_cnt !== fc[7:0] || streak_max !== sm[7:0]) begin
            errs++;
            $display("FAIL post_done done=%b busy=%b pc=%0d fc=%0d sm=%0d",
                     done, busy, pass_cnt, fail_cnt, streak_max);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        pass3 = 1'b0;
        num_rounds = 8'd0;
        seed = 16'h0000;
        tick();
        tick();
        rst = 1'b0;
        tick();
        vecs++;
        if ({packed_out(), busy, done, pass_cnt, fail_cnt, streak_max} !== '0)
        begin
            errs++;
            $display("FAIL reset_outputs got=%h busy=%b done=%b",
                     packed_out(), busy, done);
        end
        run_batch(0, 16'($urandom), '0, 1'b0);
    endtask

    task automatic test_all_pass();
        logic [255:0] p;
        p = '1;
        run_batch(10, 16'h1234, p, 1'b0);
        vecs++;
        if (pass_cnt !== 8'd10 || fail_cnt !== 8'd0 || streak_max !== 8'd10)
        begin
            errs++;
            $display("FAIL all_pass got=%0d/%0d/%0d exp=10/0/10",
                     pass_cnt, fail_cnt, streak_max);
        end
    endtask

    task automatic test_all_fail();
        run_batch(255, 16'($urandom), '0, 1'b0);
        vecs++;
        if (pass_cnt !== 8'd0 || fail_cnt !== 8'd255 || streak_max !== 8'd0)
        begin
            errs++;
            $display("FAIL all_fail got=%0d/%0d/%0d exp=0/255/0",
                     pass_cnt, fail_cnt, streak_max);
        end
    endtask

    task automatic test_seed_zero();
        run_batch(6, 16'h0000, 256'($urandom), 1'b0);
        for (int r = 0; r < 6; r++) keep[r] = obs[r];
        run_batch(6, 16'hACE1, 256'($urandom), 1'b0);
        for (int r = 0; r < 6; r++) begin
            vecs++;
            if (obs[r] !== keep[r]) begin
                errs++;
                $display("FAIL seed_zero r=%0d got=%h exp=%h",
                         r, obs[r], keep[r]);
            end
        end
    endtask

    task automatic test_pattern();
        logic [255:0] p;
        p = '0;
        p[6:0] = 7'b0111011;
        run_batch(7, 16'($urandom), p, 1'b0);
        vecs++;
        if (pass_cnt !== 8'd5 || fail_cnt !== 8'd2 || streak_max !== 8'd3)
        begin
            errs++;
            $display("FAIL pattern got=%0d/%0d/%0d exp=5/2/3",
                     pass_cnt, fail_cnt, streak_max);
        end
    endtask

    task automatic test_reset_abort();
        bit saw_done;
        logic [255:0] p;
        start = 1'b1;
        num_rounds = 8'd8;
        seed = 16'($urandom);
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        vecs++;
        if ({packed_out(), busy, done, pass_cnt, fail_cnt, streak_max} !== '0)
        begin
            errs++;
            $display("FAIL abort_outputs got=%h busy=%b done=%b",
                     packed_out(), busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        vecs++;
        if (saw_done) begin
            errs++;
            $display("FAIL abort_quiet got=1 exp=0");
        end
        p = 256'($urandom);
        run_batch(8, 16'($urandom), p, 1'b1);
    endtask

    task automatic test_random();
        logic [255:0] p;
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 8; i++) p[32*i +: 32] = $urandom;
            run_batch(int'($urandom_range(1, 20)), 16'($urandom), p,
                      1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_all_pass();
        test_all_fail();
        test_seed_zero();
        test_pattern();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
